// File: rtl/tblink_rpc_pkg.sv
// Shared TBLink RPC definitions: FSM state encodings, packet field offsets and
// the response command code, used by the command initiator and command processor.
package tblink_rpc_pkg;

    typedef enum logic [3:0] {
        IDLE,
        TX_SZ,
        TX_CMD,
        TX_ID,
        TX_PAR,
        RX_DST,
        RX_SZ,
        RX_CMD,
        RX_ID,
        RX_DAT
    } rpc_state_e;

    // Request packet: SZ, CMD, ID, then parameter bytes
    localparam int unsigned REQ_OFF_SZ   = 0;
    localparam int unsigned REQ_OFF_CMD  = 1;
    localparam int unsigned REQ_OFF_ID   = 2;
    localparam int unsigned REQ_OFF_PAR  = 3;

    // Response packet: DST, SZ, CMD, ID, then data bytes
    localparam int unsigned RSP_OFF_DST  = 0;
    localparam int unsigned RSP_OFF_SZ   = 1;
    localparam int unsigned RSP_OFF_CMD  = 2;
    localparam int unsigned RSP_OFF_ID   = 3;
    localparam int unsigned RSP_OFF_DAT  = 4;

    localparam logic [7:0] RSP_CMD_CODE = 8'h00;

    function automatic logic [7:0] min_u8(input logic [7:0] v, input int unsigned cap);
        return (32'(v) < cap) ? v : cap[7:0];
    endfunction

endpackage

// File: rtl/tblink_rpc_cmdinit.sv
// TBLink RPC command initiator: serialises one command onto the tipo byte stream
// and collects the matching response from tipi, signalling completion by toggle.
module tblink_rpc_cmdinit
    import tblink_rpc_pkg::*;
#(
    parameter int unsigned CMD_PARAMS_SZ = 1,
    parameter int unsigned CMD_RSP_SZ    = 1
) (
    input  logic                      uclock,
    input  logic                      reset,
    output logic [7:0]                tipo_dat,
    output logic                      tipo_valid,
    input  logic                      tipo_ready,
    input  logic [7:0]                tipi_dat,
    input  logic                      tipi_valid,
    output logic                      tipi_ready,
    input  logic [7:0]                cmd,
    input  logic [7:0]                cmd_sz,
    input  logic [CMD_PARAMS_SZ*8-1:0] cmd_params,
    input  logic                      cmd_put_i,
    output logic                      cmd_get_i,
    output logic [CMD_RSP_SZ*8-1:0]   cmd_rsp,
    output logic [7:0]                cmd_rsp_sz,
    output logic                      cmd_rsp_err
);

    rpc_state_e state, state_n;

    logic [7:0]                 cmd_r;
    logic [7:0]                 n_r;
    logic [7:0]                 cnt_r;
    logic [CMD_PARAMS_SZ*8-1:0] par_r;
    logic [7:0]                 id_r;
    logic [7:0]                 rem_r;
    logic [7:0]                 k_r;
    logic                       start;
    logic                       done;
    logic                       tx_acc;
    logic                       rx_acc;

    assign tx_acc = tipo_valid && tipo_ready;
    assign rx_acc = tipi_valid && tipi_ready;

    always_ff @(posedge uclock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n    = state;
        tipo_valid = 1'b0;
        tipo_dat   = 8'h00;
        tipi_ready = 1'b0;
        start      = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (cmd_put_i != cmd_get_i) begin
                    start   = 1'b1;
                    state_n = TX_SZ;
                end
            end
            TX_SZ: begin
                tipo_valid = 1'b1;
                tipo_dat   = n_r + 8'd1;
                if (tipo_ready) state_n = TX_CMD;
            end
            TX_CMD: begin
                tipo_valid = 1'b1;
                tipo_dat   = cmd_r;
                if (tipo_ready) state_n = TX_ID;
            end
            TX_ID: begin
                tipo_valid = 1'b1;
                tipo_dat   = id_r;
                if (tipo_ready) state_n = (n_r == 8'd0) ? RX_DST : TX_PAR;
            end
            TX_PAR: begin
                tipo_valid = 1'b1;
                tipo_dat   = par_r[7:0];
                if (tipo_ready && cnt_r == 8'd1) state_n = RX_DST;
            end
            RX_DST: begin
                tipi_ready = 1'b1;
                if (tipi_valid) state_n = RX_SZ;
            end
            RX_SZ: begin
                tipi_ready = 1'b1;
                if (tipi_valid) state_n = RX_CMD;
            end
            RX_CMD: begin
                tipi_ready = 1'b1;
                if (tipi_valid) state_n = RX_ID;
            end
            RX_ID: begin
                tipi_ready = 1'b1;
                if (tipi_valid) begin
                    if (rem_r == 8'd0) begin
                        done    = 1'b1;
                        state_n = IDLE;
                    end else begin
                        state_n = RX_DAT;
                    end
                end
            end
            RX_DAT: begin
                tipi_ready = 1'b1;
                if (tipi_valid && rem_r == 8'd1) begin
                    done    = 1'b1;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge uclock or posedge reset) begin
        if (reset) begin
            cmd_r       <= '0;
            n_r         <= '0;
            cnt_r       <= '0;
            par_r       <= '0;
            id_r        <= '0;
            rem_r       <= '0;
            k_r         <= '0;
            cmd_get_i   <= 1'b0;
            cmd_rsp     <= '0;
            cmd_rsp_sz  <= '0;
            cmd_rsp_err <= 1'b0;
        end else begin
            if (start) begin
                cmd_r       <= cmd;
                n_r         <= min_u8(cmd_sz, CMD_PARAMS_SZ);
                cnt_r       <= min_u8(cmd_sz, CMD_PARAMS_SZ);
                par_r       <= cmd_params;
                k_r         <= '0;
                cmd_rsp     <= '0;
                cmd_rsp_sz  <= '0;
                cmd_rsp_err <= 1'b0;
            end
            // Parameters leave LSB-first, so shift the next byte down after each accept
            if (state == TX_PAR && tx_acc) begin
                par_r <= par_r >> 8;
                cnt_r <= cnt_r - 8'd1;
            end
            if (state == RX_SZ && rx_acc) begin
                rem_r      <= (tipi_dat == 8'd0) ? 8'd0 : tipi_dat - 8'd1;
                cmd_rsp_sz <= min_u8((tipi_dat == 8'd0) ? 8'd0 : tipi_dat - 8'd1, CMD_RSP_SZ);
                if (tipi_dat == 8'd0) cmd_rsp_err <= 1'b1;
            end
            if (state == RX_CMD && rx_acc && tipi_dat != RSP_CMD_CODE) cmd_rsp_err <= 1'b1;
            if (state == RX_ID && rx_acc && tipi_dat != id_r) cmd_rsp_err <= 1'b1;
            // Bytes beyond the response capacity are counted but dropped
            if (state == RX_DAT && rx_acc) begin
                for (int unsigned i = 0; i < CMD_RSP_SZ; i++) begin
                    if (32'(k_r) == i) cmd_rsp[8*i +: 8] <= tipi_dat;
                end
                k_r   <= k_r + 8'd1;
                rem_r <= rem_r - 8'd1;
            end
            if (done) begin
                cmd_get_i <= ~cmd_get_i;
                id_r      <= id_r + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_tblink_rpc_cmdinit.sv
// Scoreboard bench for tblink_rpc_cmdinit: randomized commands and responses
// checked against a packet-level model of the request/response protocol.
module tb_tblink_rpc_cmdinit;

    localparam int unsigned PSZ = 3;
    localparam int unsigned RSZ = 2;

    logic              uclock = 1'b0;
    logic              reset;
    logic [7:0]        tipo_dat;
    logic              tipo_valid;
    logic              tipo_ready;
    logic [7:0]        tipi_dat;
    logic              tipi_valid;
    logic              tipi_ready;
    logic [7:0]        cmd;
    logic [7:0]        cmd_sz;
    logic [PSZ*8-1:0]  cmd_params;
    logic              cmd_put_i;
    logic              cmd_get_i;
    logic [RSZ*8-1:0]  cmd_rsp;
    logic [7:0]        cmd_rsp_sz;
    logic              cmd_rsp_err;

    tblink_rpc_cmdinit #(.CMD_PARAMS_SZ(PSZ), .CMD_RSP_SZ(RSZ)) dut (
        .uclock(uclock), .reset(reset),
        .tipo_dat(tipo_dat), .tipo_valid(tipo_valid), .tipo_ready(tipo_ready),
        .tipi_dat(tipi_dat), .tipi_valid(tipi_valid), .tipi_ready(tipi_ready),
        .cmd(cmd), .cmd_sz(cmd_sz), .cmd_params(cmd_params),
        .cmd_put_i(cmd_put_i), .cmd_get_i(cmd_get_i),
        .cmd_rsp(cmd_rsp), .cmd_rsp_sz(cmd_rsp_sz), .cmd_rsp_err(cmd_rsp_err)
    );

    always #5 uclock = ~uclock;

    typedef struct { logic [7:0] b; bit first; } tx_t;
    typedef struct { logic [RSZ*8-1:0] rsp; logic [7:0] sz; logic err; } res_t;

    tx_t        exp_tx[$];
    res_t       exp_res[$];
    logic [7:0] dat_q[$];

    int          n_tests = 0;
    int          n_fails = 0;
    int          cyc = 0;
    int          last_acc = 0;
    int          n_acc = 0;
    int          rdy_mode = 0;
    logic [7:0]  exp_id = 8'h00;
    logic        get_prev = 1'b0;
    logic        hold_pend = 1'b0;
    logic [7:0]  hold_dat = 8'h00;

    initial forever begin
        @(posedge uclock);
        cyc++;
    end

    initial begin
        tipo_ready = 1'b1;
        forever begin
            @(posedge uclock);
            #1;
            case (rdy_mode)
                0:       tipo_ready = 1'b1;
                1:       tipo_ready = ~tipo_ready;
                default: tipo_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: tipo bytes, hold stability, and completion results
    initial forever begin
        tx_t  e;
        res_t r;
        @(negedge uclock);
        if (reset) begin
            get_prev  = cmd_get_i;
            hold_pend = 1'b0;
            continue;
        end
        if (hold_pend) begin
            check("tx_hold_valid", 32'(tipo_valid), 32'd1);
            check("tx_hold_dat", 32'(tipo_dat), 32'(hold_dat));
        end
        if (tipo_valid && tipi_ready) begin
            n_fails++;
            $display("FAIL tx_rx_overlap: tipo_valid and tipi_ready both high (cycle %0d)", cyc);
        end
        if (tipo_valid && tipo_ready) begin
            n_acc++;
            if (exp_tx.size() == 0) begin
                n_fails++;
                $display("FAIL tx_unexpected: byte %0h with nothing expected", tipo_dat);
            end else begin
                e = exp_tx.pop_front();
                check("tx_byte", 32'(tipo_dat), 32'(e.b));
                if (rdy_mode == 0 && !e.first) check("tx_no_bubble", cyc, last_acc + 1);
            end
            last_acc = cyc;
        end
        hold_pend = tipo_valid && !tipo_ready;
        hold_dat  = tipo_dat;
        if (cmd_get_i != get_prev) begin
            if (exp_res.size() == 0) begin
                n_fails++;
                $display("FAIL rsp_unexpected: completion toggle with nothing expected");
            end else begin
                r = exp_res.pop_front();
                check("rsp_data", 32'(cmd_rsp), 32'(r.rsp));
                check("rsp_sz", 32'(cmd_rsp_sz), 32'(r.sz));
                check("rsp_err", 32'(cmd_rsp_err), 32'(r.err));
            end
            get_prev = cmd_get_i;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        if (rdy_mode == 2) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge uclock);
                #1;
            end
        end
        tipi_valid = 1'b1;
        tipi_dat   = b;
        for (int i = 0; i < 500; i++) begin
            @(negedge uclock);
            if (tipi_ready) begin
                @(posedge uclock);
                #1;
                tipi_valid = 1'b0;
                return;
            end
        end
        n_fails++;
        $display("FAIL rx_timeout: byte %0h never consumed", b);
        tipi_valid = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 2000; i++) begin
            @(negedge uclock);
            if (cmd_get_i == cmd_put_i) begin
                @(posedge uclock);
                #1;
                return;
            end
        end
        n_fails++;
        $display("FAIL done_timeout: get %0b put %0b", cmd_get_i, cmd_put_i);
    endtask

    task automatic run_txn(input logic [7:0] c, input logic [7:0] csz, input logic [23:0] prm,
                           input logic [7:0] rsz, input logic [7:0] rcmd, input logic [7:0] rid);
        int unsigned n, m, keep;
        logic [7:0]  d[$];
        res_t        r;
        n = (32'(csz) < PSZ) ? 32'(csz) : PSZ;
        exp_tx.push_back('{b: 8'(n + 1), first: 1'b1});
        exp_tx.push_back('{b: c, first: 1'b0});
        exp_tx.push_back('{b: exp_id, first: 1'b0});
        for (int k = 0; k < int'(n); k++) exp_tx.push_back('{b: prm[8*k +: 8], first: 1'b0});
        m = (rsz == 8'd0) ? 0 : 32'(rsz) - 1;
        for (int k = 0; k < int'(m); k++) d.push_back(dat_q.size() > 0 ? dat_q.pop_front() : 8'($urandom));
        keep  = (m < RSZ) ? m : RSZ;
        r.rsp = '0;
        for (int k = 0; k < int'(keep); k++) r.rsp[8*k +: 8] = d[k];
        r.sz  = 8'(keep);
        r.err = (rsz == 8'd0) || (rcmd != 8'd0) || (rid != exp_id);
        exp_res.push_back(r);
        cmd        = c;
        cmd_sz     = csz;
        cmd_params = prm;
        cmd_put_i  = ~cmd_put_i;
        @(posedge uclock);
        #1;
        cmd        = 8'($urandom);
        cmd_sz     = 8'($urandom);
        cmd_params = 24'($urandom);
        send_byte(8'($urandom));
        send_byte(rsz);
        send_byte(rcmd);
        send_byte(rid);
        foreach (d[k]) send_byte(d[k]);
        wait_done();
        exp_id = exp_id + 8'd1;
    endtask

    task automatic run_random();
        int         kind;
        logic [7:0] rsz, rcmd, rid;
        kind = $urandom_range(0, 9);
        rsz  = 8'($urandom_range(1, 6));
        rcmd = 8'h00;
        rid  = exp_id;
        if (kind == 0) rcmd = 8'($urandom_range(1, 255));
        if (kind == 1) rid = exp_id + 8'd1;
        if (kind == 2) rsz = 8'h00;
        run_txn(8'($urandom_range(1, 255)), 8'($urandom_range(0, 5)), 24'($urandom), rsz, rcmd, rid);
    endtask

    initial begin
        reset      = 1'b1;
        tipi_valid = 1'b0;
        tipi_dat   = 8'h00;
        cmd        = 8'h00;
        cmd_sz     = 8'h00;
        cmd_params = '0;
        cmd_put_i  = 1'b0;
        repeat (3) @(posedge uclock);
        @(negedge uclock);
        check("rst_tipo_valid", 32'(tipo_valid), 32'd0);
        check("rst_tipo_dat", 32'(tipo_dat), 32'd0);
        check("rst_tipi_ready", 32'(tipi_ready), 32'd0);
        check("rst_get", 32'(cmd_get_i), 32'd0);
        check("rst_rsp", 32'(cmd_rsp), 32'd0);
        check("rst_rsp_sz", 32'(cmd_rsp_sz), 32'd0);
        check("rst_rsp_err", 32'(cmd_rsp_err), 32'd0);
        @(posedge uclock);
        #1;
        reset = 1'b0;
        @(posedge uclock);
        #1;

        // Basic two-parameter command with one data byte in the reply
        rdy_mode = 0;
        dat_q.push_back(8'h77);
        run_txn(8'h05, 8'h02, 24'h00BBAA, 8'h02, 8'h00, exp_id);

        // No parameters, tipo_ready alternating
        rdy_mode = 1;
        run_txn(8'h3C, 8'h00, 24'h0, 8'h01, 8'h00, exp_id);

        // Wrong ID in reply, then a clean command
        rdy_mode = 0;
        run_txn(8'h11, 8'h01, 24'h000042, 8'h03, 8'h00, exp_id + 8'd1);
        run_txn(8'h12, 8'h01, 24'h000043, 8'h01, 8'h00, exp_id);

        // Reply data longer than capacity, plus oversize parameter count
        dat_q.push_back(8'h11);
        dat_q.push_back(8'h22);
        dat_q.push_back(8'h33);
        run_txn(8'h21, 8'h07, 24'hC0FFEE, 8'h04, 8'h00, exp_id);

        // Random traffic with random handshakes
        rdy_mode = 2;
        for (int i = 0; i < 40; i++) run_random();

        // Enough back-to-back commands to wrap the ID counter
        rdy_mode = 0;
        for (int i = 0; i < 260; i++) run_random();

        // Reset while parameters are being sent
        rdy_mode = 0;
        begin
            int base;
            bit hit;
            base = n_acc;
            hit  = 1'b0;
            exp_tx.push_back('{b: 8'h04, first: 1'b1});
            exp_tx.push_back('{b: 8'h09, first: 1'b0});
            exp_tx.push_back('{b: exp_id, first: 1'b0});
            exp_tx.push_back('{b: 8'hA1, first: 1'b0});
            cmd        = 8'h09;
            cmd_sz     = 8'h03;
            cmd_params = 24'hA3A2A1;
            cmd_put_i  = ~cmd_put_i;
            for (int i = 0; i < 100 && !hit; i++) begin
                @(negedge uclock);
                if (n_acc >= base + 4) hit = 1'b1;
            end
            check("rst_mid_reached", 32'(hit), 32'd1);
            #2;
            reset     = 1'b1;
            cmd_put_i = 1'b0;
            #1;
            check("rst_mid_tipo_valid", 32'(tipo_valid), 32'd0);
            @(posedge uclock);
            #1;
            exp_tx.delete();
            exp_res.delete();
            exp_id = 8'h00;
            check("rst_mid_tipo_valid_next", 32'(tipo_valid), 32'd0);
            check("rst_mid_get", 32'(cmd_get_i), 32'd0);
            check("rst_mid_tipi_ready", 32'(tipi_ready), 32'd0);
            check("rst_mid_rsp_err", 32'(cmd_rsp_err), 32'd0);
            @(posedge uclock);
            #1;
            reset = 1'b0;
            @(posedge uclock);
            #1;
        end

        // ID restarts at zero after reset
        run_txn(8'h44, 8'h01, 24'h00005A, 8'h02, 8'h00, exp_id);
        check("tx_queue_drained", exp_tx.size(), 0);
        check("rsp_queue_drained", exp_res.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fails);
        $finish;
    end

endmodule

// File: doc/tblink_rpc_cmdinit.md
TBLINK_RPC_CMDINIT -- requirements
Module: tblink_rpc_cmdinit

Interface
REQ-001 SHALL have parameter CMD_PARAMS_SZ, default 1, request parameter capacity in bytes (>=1).
REQ-002 SHALL have parameter CMD_RSP_SZ, default 1, response data capacity in bytes (>=1).
REQ-003 uclock  in  1  clock; reset  in  1  reset, asynchronous, active-high.
REQ-004 tipo_dat  out  8  request byte stream; tipo_valid  out  1; tipo_ready  in  1.
REQ-005 tipi_dat  in  8  response byte stream; tipi_valid  in  1; tipi_ready  out  1.
REQ-006 cmd  in  8  command code (non-zero); cmd_sz  in  8  param byte count; cmd_params  in  CMD_PARAMS_SZ*8  params, byte 0 in [7:0].
REQ-007 cmd_put_i  in  1  request toggle; cmd_get_i  out  1  completion toggle.
REQ-008 cmd_rsp  out  CMD_RSP_SZ*8  response data, first data byte in [7:0]; cmd_rsp_sz  out  8  data bytes received; cmd_rsp_err  out  1  response malformed.

Function
REQ-009 SHALL start a transaction in IDLE when cmd_put_i != cmd_get_i, latching cmd, min(cmd_sz, CMD_PARAMS_SZ) as N, and cmd_params in that cycle; later input changes SHALL be ignored.
REQ-010 SHALL transmit, in order: SZ=N+1, CMD, ID, then params byte 0..N-1; total N+3 bytes.
REQ-011 ID SHALL be an internal 8-bit counter, 0 after reset, incremented (mod 256, 255->0) at each completion.
REQ-012 tipo_valid SHALL assert the cycle after the start cycle; each byte held stable until tipo_valid && tipo_ready; no bubbles between bytes when tipo_ready stays high.
REQ-013 States: IDLE, TX_SZ, TX_CMD, TX_ID, TX_PAR, RX_DST, RX_SZ, RX_CMD, RX_ID, RX_DAT; N=0 skips TX_PAR (TX_ID -> RX_DST).
REQ-014 tipi_ready SHALL be high only in RX_* states; a byte is consumed on tipi_valid && tipi_ready.
REQ-015 Response byte order: DST (ignored), SZ (data bytes M=SZ-1), CMD (must be 0), ID (must equal sent ID), then M data bytes.
REQ-016 SZ==0 SHALL be treated as M=0 and set error.
REQ-017 Data byte k<CMD_RSP_SZ SHALL be written to cmd_rsp[8k+:8]; bytes k>=CMD_RSP_SZ SHALL be consumed and discarded; unwritten bytes SHALL be 0 (cleared at start).
REQ-018 cmd_rsp_sz SHALL equal min(M, CMD_RSP_SZ).
REQ-019 cmd_rsp_err SHALL be set on CMD!=0, ID mismatch, or SZ==0; packet still consumed by its SZ; cleared at next start.
REQ-020 On the cycle the last response byte is consumed (ID byte if M=0) the block SHALL toggle cmd_get_i and return to IDLE; cmd_rsp/sz/err valid when cmd_get_i==cmd_put_i.
REQ-021 Next transaction SHALL NOT start earlier than the cycle after completion; one outstanding transaction max.
REQ-022 tipi bytes arriving while not in RX_* SHALL be left unconsumed (stall).

Reset
REQ-023 Reset SHALL force IDLE; tipo_valid=0, tipo_dat=0, tipi_ready=0, cmd_get_i=0, cmd_rsp=0, cmd_rsp_sz=0, cmd_rsp_err=0, ID=0.
REQ-024 Reset mid-transaction SHALL abandon it without completion toggle; client SHALL return cmd_put_i to 0.

Structure
REQ-025 State encodings, packet field offsets, and response CMD code 0 SHALL reside in a shared tblink_rpc package used also by the command processor.
REQ-026 Single module; no sub-module required.

Verification
REQ-027 cmd=0x05, cmd_sz=2, params=0xBBAA, toggle put; tipo_ready=1 -> bytes 03,05,00,AA,BB consecutive; reply 00,02,00,00,77 -> cmd_rsp[7:0]=0x77, rsp_sz=1, err=0, get toggles.
REQ-028 cmd_sz=0, tipo_ready toggling 1/0 -> bytes 01,cmd,ID each held until accepted; reply 00,01,00,ID -> rsp_sz=0, err=0.
REQ-029 Reply with ID+1 -> err=1, packet fully consumed, get toggles, next command starts cleanly.
REQ-030 CMD_RSP_SZ=1, reply SZ=4 (3 data 11,22,33) -> cmd_rsp=0x11, rsp_sz=1, all bytes consumed.
REQ-031 256 back-to-back commands -> IDs 00..FF then 00; reset asserted during TX_PAR -> tipo_valid=0 next cycle, get_i=0.
